// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the register bank.
// Latency: n/a (package only).
// Backpressure: n/a.
package reg_bank_pkg;

    localparam int WIDTH  = 32;  // data width of each register
    localparam int NREGS  = 16;  // register count, tied to the 16-bit one-hot enable
    localparam int ADDR_W = 4;   // register address width

    // True when exactly one bit of v is set. Clearing the lowest set bit
    // of a one-hot value leaves zero; zero itself is excluded explicitly.
    function automatic logic is_onehot(input logic [NREGS-1:0] v);
        return (v != '0) && ((v & (v - NREGS'(1))) == '0);
    endfunction

endpackage

// File: rtl/reg_bank_dec.sv
// 4-to-16 one-hot decoder.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   sel    - binary register address
//   onehot - one-hot decode of sel, bit sel set
module reg_bank_dec (
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/reg_bank.sv
// Register file with write-back bypass, issue scoreboard and multi-write error flag.
// Latency: reads combinational (zero cycles), writes and scoreboard update at the next clk edge.
// Backpressure: none; every write and issue is taken, hazard is advisory to the issue logic.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   enable, wdata       - one-hot write-back enable and data
//   src_a/src_b         - read addresses; rdata_a/rdata_b read data (bypassed)
//   issue_valid/dest    - instruction issue, marks dest busy
//   busy                - per-register outstanding-write scoreboard
//   hazard              - a source is busy and not being written this cycle
//   err_multi           - sticky, enable carried more than one set bit
module reg_bank #(
    parameter int WIDTH = reg_bank_pkg::WIDTH,
    parameter int NREGS = reg_bank_pkg::NREGS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREGS-1:0]   enable,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [3:0]         src_a,
    input  logic [3:0]         src_b,
    output logic [WIDTH-1:0]   rdata_a,
    output logic [WIDTH-1:0]   rdata_b,
    input  logic               issue_valid,
    input  logic [3:0]         issue_dest,
    output logic [NREGS-1:0]   busy,
    output logic               hazard,
    output logic               err_multi
);

    import reg_bank_pkg::*;

    logic [WIDTH-1:0] regs [NREGS];
    logic             wen_ok;
    logic             wen_multi;
    logic [NREGS-1:0] wr_mask;
    logic [NREGS-1:0] set_mask;

    // Only a clean one-hot enable may write, clear busy or bypass; zero
    // and multi-bit enables collapse to an empty mask.
    assign wen_ok    = is_onehot(enable);
    assign wen_multi = (enable != '0) && !wen_ok;
    assign wr_mask   = wen_ok ? enable : '0;

    reg_bank_dec u_dec (
        .sel    (issue_dest),
        .onehot (set_mask)
    );

    // Register storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_mask[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Scoreboard: clear on write-back first, then OR in the issue so a
    // same-cycle issue to the register being written leaves it busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_mask) | (issue_valid ? set_mask : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_multi <= 1'b0;
        end else if (wen_multi) begin
            err_multi <= 1'b1;
        end
    end

    // Reads with same-cycle bypass of the write-back value
    always_comb begin
        rdata_a = wr_mask[src_a] ? wdata : regs[src_a];
        rdata_b = wr_mask[src_b] ? wdata : regs[src_b];
    end

    // A busy source being written back this cycle is satisfied by the bypass.
    assign hazard = (busy[src_a] & ~wr_mask[src_a]) |
                    (busy[src_b] & ~wr_mask[src_b]);

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] enable;
    logic [31:0] wdata;
    logic [3:0]  src_a, src_b;
    logic [31:0] rdata_a, rdata_b;
    logic        issue_valid;
    logic [3:0]  issue_dest;
    logic [15:0] busy;
    logic        hazard;
    logic        err_multi;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic        m_err;

    always #5 clk = ~clk;

    reg_bank dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .wdata       (wdata),
        .src_a       (src_a),
        .src_b       (src_b),
        .rdata_a     (rdata_a),
        .rdata_b     (rdata_b),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .busy        (busy),
        .hazard      (hazard),
        .err_multi   (err_multi)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit single(input logic [15:0] e);
        return $countones(e) == 1;
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        if (single(enable) && enable[a]) return wdata;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_outputs(input string tag);
        logic exp_hz;
        exp_hz = (m_busy[src_a] && !(single(enable) && enable[src_a])) ||
                 (m_busy[src_b] && !(single(enable) && enable[src_b]));
        chk({tag, ".rdata_a"}, rdata_a, exp_read(src_a));
        chk({tag, ".rdata_b"}, rdata_b, exp_read(src_b));
        chk({tag, ".hazard"},  {31'd0, hazard}, {31'd0, exp_hz});
        chk({tag, ".busy"},    {16'd0, busy}, {16'd0, m_busy});
        chk({tag, ".err"},     {31'd0, err_multi}, {31'd0, m_err});
    endtask

    // Apply inputs shortly after an edge, check before the next edge.
    task automatic drive(input logic [15:0] en, input logic [31:0] wd,
                         input logic [3:0] sa, input logic [3:0] sb,
                         input logic iv, input logic [3:0] id, input string tag);
        enable = en; wdata = wd; src_a = sa; src_b = sb;
        issue_valid = iv; issue_dest = id;
        #2;
        check_outputs(tag);
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic edge_update();
        @(posedge clk);
        if (!reset) begin
            if (single(enable)) begin
                for (int i = 0; i < 16; i++)
                    if (enable[i]) begin
                        m_regs[i] = wdata;
                        m_busy[i] = 1'b0;
                    end
            end else if (enable != 16'h0) begin
                m_err = 1'b1;
            end
            if (issue_valid) m_busy[issue_dest] = 1'b1;
        end
        #1;
    endtask

    task automatic step(input logic [15:0] en, input logic [31:0] wd,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input logic iv, input logic [3:0] id, input string tag);
        drive(en, wd, sa, sb, iv, id, tag);
        edge_update();
    endtask

    task automatic idle(input logic [3:0] sa, input logic [3:0] sb, input string tag);
        step(16'h0, 32'h0, sa, sb, 1'b0, 4'd0, tag);
    endtask

    initial begin
        logic [15:0] en;
        logic [31:0] wd;
        logic [3:0]  a, b;
        int          k, j;

        // Reset with write/issue activity presented; all of it must be discarded.
        reset = 1'b1;
        enable = 16'h0001; wdata = 32'hA5A5A5A5; src_a = 4'd0; src_b = 4'd0;
        issue_valid = 1'b1; issue_dest = 4'd2;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", {16'd0, busy}, 32'h0);
        chk("rst.err",  {31'd0, err_multi}, 32'h0);
        enable = 16'h0; issue_valid = 1'b0;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            src_a = 4'(i); src_b = 4'(15 - i);
            #1;
            chk("post_rst.rdata_a", rdata_a, 32'h0);
            chk("post_rst.rdata_b", rdata_b, 32'h0);
        end
        chk("post_rst.hazard", {31'd0, hazard}, 32'h0);
        @(posedge clk); #1;

        // Single write then read back, others stay zero
        step(16'h0008, 32'hDEADBEEF, 4'd0, 4'd1, 1'b0, 4'd0, "wr3");
        drive(16'h0, 32'h0, 4'd3, 4'd0, 1'b0, 4'd0, "rd3");
        chk("rd3.const", rdata_a, 32'hDEADBEEF);
        edge_update();
        for (int i = 0; i < 16; i++) idle(4'(i), 4'(i), "scan");

        // Same-cycle bypass on port B
        drive(16'h0020, 32'h12345678, 4'd0, 4'd5, 1'b0, 4'd0, "byp5");
        chk("byp5.const", rdata_b, 32'h12345678);
        edge_update();
        idle(4'd5, 4'd5, "rd5");

        // Multi-bit enable: no write, no bypass, sticky error
        step(16'h0001, 32'h11111111, 4'd0, 4'd1, 1'b0, 4'd0, "wr0");
        step(16'h0003, 32'hFFFFFFFF, 4'd0, 4'd1, 1'b0, 4'd0, "multi");
        for (int i = 0; i < 10; i++) idle(4'd0, 4'd1, "multi_hold");
        chk("multi.err_const", {31'd0, err_multi}, 32'h1);

        // Scoreboard set, hazard, clear via write-back
        step(16'h0, 32'h0, 4'd0, 4'd0, 1'b1, 4'd7, "iss7");
        drive(16'h0, 32'h0, 4'd7, 4'd0, 1'b0, 4'd0, "haz7");
        chk("haz7.busy_const", {16'd0, busy}, 32'h0080);
        chk("haz7.hz_const", {31'd0, hazard}, 32'h1);
        edge_update();
        drive(16'h0080, 32'hCAFEF00D, 4'd7, 4'd0, 1'b0, 4'd0, "wb7");
        chk("wb7.hz_const", {31'd0, hazard}, 32'h0);
        edge_update();
        chk("wb7.busy_const", {16'd0, busy}, 32'h0);

        // Same-cycle issue and write-back to reg4: set wins, data lands
        step(16'h0, 32'h0, 4'd0, 4'd0, 1'b1, 4'd4, "iss4");
        step(16'h0010, 32'h44444444, 4'd4, 4'd4, 1'b1, 4'd4, "iss_wb4");
        drive(16'h0, 32'h0, 4'd4, 4'd4, 1'b0, 4'd0, "chk4");
        chk("chk4.busy4", {31'd0, busy[4]}, 32'h1);
        chk("chk4.data", rdata_a, 32'h44444444);
        edge_update();
        // Re-issue to a busy register, then invalid write must not clear it
        step(16'h0, 32'h0, 4'd4, 4'd0, 1'b1, 4'd4, "reiss4");
        step(16'h0030, 32'h0, 4'd4, 4'd5, 1'b0, 4'd0, "multi_busy");
        idle(4'd4, 4'd5, "after_multi");

        // Mid-stream asynchronous reset with busy=F0 and live data
        step(16'h0010, 32'h0, 4'd0, 4'd0, 1'b1, 4'd5, "iss5");
        step(16'h0, 32'h0, 4'd0, 4'd0, 1'b1, 4'd6, "iss6");
        step(16'h0, 32'h0, 4'd0, 4'd0, 1'b1, 4'd7, "iss7b");
        step(16'h0, 32'h0, 4'd0, 4'd0, 1'b1, 4'd4, "iss4b");
        drive(16'h0, 32'h0, 4'd3, 4'd0, 1'b0, 4'd0, "pre_rst");
        chk("pre_rst.busy_const", {16'd0, busy}, 32'h00F0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst.busy", {16'd0, busy}, 32'h0);
        chk("mid_rst.err",  {31'd0, err_multi}, 32'h0);
        chk("mid_rst.reg3", rdata_a, 32'h0);
        chk("mid_rst.reg0", rdata_b, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 3);
            if (k == 0) en = 16'h0;
            else if (k == 3) begin
                k = $urandom_range(0, 15);
                j = (k + $urandom_range(1, 15)) % 16;
                en = (16'h1 << k) | (16'h1 << j) | 16'($urandom_range(0, 1) ? $urandom : 0);
            end else en = 16'h1 << $urandom_range(0, 15);
            wd = $urandom;
            a  = 4'($urandom_range(0, 15));
            b  = ($urandom_range(0, 7) == 0) ? a : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                chk("rnd_rst.busy", {16'd0, busy}, 32'h0);
                @(posedge clk); #1;
                reset = 1'b0;
                #1;
            end
            step(en, wd, a, b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register and of every data port.
REQ-002 Parameter NREGS, default 16, register count; fixed at 16 to match the 16-bit one-hot write enable.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  16  one-hot write enable from the destination decoder; bit i selects register i.
REQ-006 wdata  input  WIDTH  write-back data.
REQ-007 src_a  input  4  read port A address.
REQ-008 src_b  input  4  read port B address.
REQ-009 rdata_a  output  WIDTH  read port A data.
REQ-010 rdata_b  output  WIDTH  read port B data.
REQ-011 issue_valid  input  1  an instruction targeting issue_dest is issued this cycle.
REQ-012 issue_dest  input  4  destination register of the issued instruction.
REQ-013 busy  output  16  scoreboard; bit i set means register i has a write outstanding.
REQ-014 hazard  output  1  a source operand is busy and not being written this cycle.
REQ-015 err_multi  output  1  sticky flag; enable carried more than one set bit.

Function
REQ-016 Write: at a rising clk edge with enable exactly one-hot (bit i), reg[i] SHALL load wdata.
REQ-017 When enable is all-zero, no register SHALL change.
REQ-018 When enable has two or more set bits, no register SHALL change and err_multi SHALL set at that edge, holding until reset.
REQ-019 Reads are combinational, zero latency: rdata_a = reg[src_a] and rdata_b = reg[src_b].
REQ-020 Bypass: when enable is one-hot with bit src_a set, rdata_a SHALL equal wdata in that same cycle; port B behaves likewise. No bypass SHALL apply when enable is invalid (zero or multi-bit).
REQ-021 Scoreboard set: issue_valid high at an edge SHALL set busy[issue_dest].
REQ-022 Scoreboard clear: a valid one-hot write to register i SHALL clear busy[i] at that edge.
REQ-023 Simultaneous issue and valid write to the same register: the set wins and busy[i] remains 1.
REQ-024 Issue to an already-busy register: busy stays 1; no error is raised.
REQ-025 Invalid (multi-bit) writes SHALL NOT clear any busy bit.
REQ-026 hazard = (busy[src_a] AND NOT valid write to src_a this cycle) OR the same term for src_b; purely combinational.
REQ-027 src_a equal to src_b is legal; both ports return identical data.

Reset
REQ-028 While reset is high, all registers SHALL be 0, busy SHALL be 16'h0000 and err_multi SHALL be 0, independent of clk.
REQ-029 Writes and issues presented while reset is high SHALL be discarded; the first update occurs at the first rising clk edge after reset deasserts.
REQ-030 After reset, rdata_a and rdata_b SHALL read 0 and hazard SHALL read 0.

Structure
REQ-031 Shared package reg_bank_pkg SHALL hold WIDTH, NREGS, the address width (4) and a one-hot validity function (exactly one bit set).
REQ-032 The existing 4-to-16 decoder module SHALL be instantiated once to convert issue_dest into the one-hot busy-set mask; no other sub-modules.
REQ-033 Register storage SHALL be a flop array with asynchronous reset; no memory macro.

Verification
REQ-034 Reset, then enable=16'h0008 and wdata=32'hDEADBEEF for one cycle; next cycle src_a=3 -> rdata_a=32'hDEADBEEF and all other registers read 0.
REQ-035 Bypass: enable=16'h0020, wdata=32'h12345678, src_b=5 in the same cycle -> rdata_b=32'h12345678 before the edge.
REQ-036 Multi-bit enable=16'h0003 with wdata=32'hFFFFFFFF -> reg0 and reg1 unchanged, err_multi=1 from the next cycle and still 1 ten cycles later; reset clears it.
REQ-037 Scoreboard: issue_valid=1, issue_dest=7 -> busy=16'h0080. With src_a=7: hazard=1; in the cycle enable=16'h0080 is driven, hazard=0; after that edge busy=16'h0000.
REQ-038 Same-cycle issue_dest=4 and enable=16'h0010 with busy[4]=1 -> busy[4] stays 1 and reg4 is updated.
REQ-039 Assert reset mid-stream with busy=16'h00F0 and nonzero registers -> busy, registers and err_multi read 0 immediately, without waiting for a clk edge.
